// File: rtl/lsq_load_port.sv
// Load port: credit-limited address pass-through plus an in-order return-data FIFO; LSQ_LOAD_BYPASS_EN adds an empty-FIFO bypass.
// Latency: address 0 cycles, data 1 cycle (0 with bypass); backpressure via valid/ready, new issues stall at MAX_OUTSTANDING.

module lsq_load_port_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           pushValid,
   output logic                           pushReady,
   input  logic [WIDTH-1:0]               pushData,
   output logic                           popValid,
   input  logic                           popReady,
   output logic [WIDTH-1:0]               popData,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wrPtr;
   logic [PW-1:0]    rdPtr;
   logic             pushFire;
   logic             popFire;

   function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   // Full refuses a push even when a pop happens in the same cycle.
   assign pushReady = (count < FULL_CNT);
   assign popValid  = (count != '0);
   assign pushFire  = pushValid && pushReady;
   assign popFire   = popValid && popReady;
   assign popData   = mem[rdPtr];

   always_ff @(posedge clk) begin
      if (pushFire) begin
         mem[wrPtr] <= pushData;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (pushFire) begin
            wrPtr <= nextPtr(wrPtr);
         end
         if (popFire) begin
            rdPtr <= nextPtr(rdPtr);
         end
         case ({pushFire, popFire})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

module lsq_load_port #(
   parameter int DATA_WIDTH      = 32,
   parameter int ADDR_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] addrIn,
   input  logic                  addrIn_valid,
   output logic                  addrIn_ready,
   output logic [ADDR_WIDTH-1:0] addrOut,
   output logic                  addrOut_valid,
   input  logic                  addrOut_ready,
   input  logic [DATA_WIDTH-1:0] dataFromMem,
   input  logic                  dataFromMem_valid,
   output logic                  dataFromMem_ready,
   output logic [DATA_WIDTH-1:0] dataOut,
   output logic                  dataOut_valid,
   input  logic                  dataOut_ready
);

   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

   logic [CW-1:0]         outstanding;
   logic                  canIssue;
   logic                  addrFire;
   logic                  dataOutFire;

   logic                  fifoPushValid;
   logic                  fifoPushReady;
   logic                  fifoPopValid;
   logic                  fifoPopReady;
   logic [DATA_WIDTH-1:0] fifoHead;
   logic [CW-1:0]         fifoCount;

   // A retire in this cycle does not open a slot until the next cycle.
   assign canIssue      = (outstanding < MAX_CNT);
   assign addrOut       = addrIn;
   assign addrOut_valid = addrIn_valid && canIssue;
   assign addrIn_ready  = addrOut_ready && canIssue;
   assign addrFire      = addrOut_valid && addrOut_ready;
   assign dataOutFire   = dataOut_valid && dataOut_ready;

   assign dataFromMem_ready = fifoPushReady;

`ifdef LSQ_LOAD_BYPASS_EN
   logic bypassNow;

   // An empty FIFO lets the returning word straight through; it is only
   // written when the consumer cannot take it this cycle.
   assign bypassNow     = (fifoCount == '0) && dataFromMem_valid;
   assign dataOut       = bypassNow ? dataFromMem : fifoHead;
   assign dataOut_valid = fifoPopValid || bypassNow;
   assign fifoPushValid = dataFromMem_valid && !(bypassNow && dataOut_ready);
   assign fifoPopReady  = dataOut_ready;
`else
   assign dataOut       = fifoHead;
   assign dataOut_valid = fifoPopValid;
   assign fifoPushValid = dataFromMem_valid;
   assign fifoPopReady  = dataOut_ready;
`endif

   lsq_load_port_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (MAX_OUTSTANDING)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .pushValid (fifoPushValid),
      .pushReady (fifoPushReady),
      .pushData  (dataFromMem),
      .popValid  (fifoPopValid),
      .popReady  (fifoPopReady),
      .popData   (fifoHead),
      .count     (fifoCount)
   );

   // Underflow guard only matters for the illegal return-with-nothing-issued case.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outstanding <= '0;
      end else begin
         case ({addrFire, dataOutFire && (outstanding != '0)})
            2'b10:   outstanding <= outstanding + CW'(1);
            2'b01:   outstanding <= outstanding - CW'(1);
            default: outstanding <= outstanding;
         endcase
      end
   end

endmodule

// File: tb/tb_lsq_load_port.sv
// Bench for lsq_load_port: directed vector table, hand sequences for credit/ordering/reset corners,
// then random traffic against a queue-based reference model.
module tb_lsq_load_port;

   localparam int DW   = 32;
   localparam int AW   = 32;
   localparam int MAXO = 4;
`ifdef LSQ_LOAD_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] addrIn;
   logic          addrIn_valid;
   logic          addrIn_ready;
   logic [AW-1:0] addrOut;
   logic          addrOut_valid;
   logic          addrOut_ready;
   logic [DW-1:0] dataFromMem;
   logic          dataFromMem_valid;
   logic          dataFromMem_ready;
   logic [DW-1:0] dataOut;
   logic          dataOut_valid;
   logic          dataOut_ready;

   always #5 clk = ~clk;

   lsq_load_port #(
      .DATA_WIDTH      (DW),
      .ADDR_WIDTH      (AW),
      .MAX_OUTSTANDING (MAXO)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .addrIn            (addrIn),
      .addrIn_valid      (addrIn_valid),
      .addrIn_ready      (addrIn_ready),
      .addrOut           (addrOut),
      .addrOut_valid     (addrOut_valid),
      .addrOut_ready     (addrOut_ready),
      .dataFromMem       (dataFromMem),
      .dataFromMem_valid (dataFromMem_valid),
      .dataFromMem_ready (dataFromMem_ready),
      .dataOut           (dataOut),
      .dataOut_valid     (dataOut_valid),
      .dataOut_ready     (dataOut_ready)
   );

   int nCmp = 0;
   int nBad = 0;

   // Reference model: number of loads in flight, buffered words, and a
   // memory that answers issued loads in order with random data.
   int            mOut;
   logic [DW-1:0] mFifo[$];
   logic [DW-1:0] memQ[$];
   bit            autoMem;
   int            mIssued;
   int            dutDelivered;

   typedef struct {
      bit            aiv;
      logic [AW-1:0] addr;
      bit            aor;
      bit            eAov;
      bit            eAir;
   } vec_t;

   vec_t tbl[9];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nCmp++;
      if (act !== exp) begin
         nBad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic modelClear();
      mOut = 0;
      mFifo.delete();
      memQ.delete();
   endtask

   // One clock cycle: inputs are already applied; compare at the falling
   // edge, then advance the model with the fires it predicts.
   task automatic cyc();
      bit            eAov, eAir, eDfmR, eDov, byp, aF, dF, pF;
      logic [DW-1:0] eDo, inData;
      @(negedge clk);
      byp    = BYP && (mFifo.size() == 0) && dataFromMem_valid;
      eAov   = addrIn_valid && (mOut < MAXO);
      eAir   = addrOut_ready && (mOut < MAXO);
      eDfmR  = mFifo.size() < MAXO;
      eDov   = (mFifo.size() > 0) || byp;
      eDo    = byp ? dataFromMem : ((mFifo.size() > 0) ? mFifo[0] : '0);
      inData = dataFromMem;
      chk("addrOut_valid", addrOut_valid, eAov);
      chk("addrIn_ready", addrIn_ready, eAir);
      chk("addrOut", addrOut, addrIn);
      chk("dataFromMem_ready", dataFromMem_ready, eDfmR);
      chk("dataOut_valid", dataOut_valid, eDov);
      if (eDov) chk("dataOut", dataOut, eDo);
      if (dataOut_valid && dataOut_ready) dutDelivered++;
      aF = eAov && addrOut_ready;
      dF = eDov && dataOut_ready;
      pF = dataFromMem_valid && eDfmR;
      @(posedge clk);
      if (aF) begin
         mOut++;
         mIssued++;
         if (autoMem) memQ.push_back(DW'($urandom));
      end
      if (dF && mOut > 0) mOut--;
      if (pF && autoMem) void'(memQ.pop_front());
      if (!(byp && dF)) begin
         if (dF) void'(mFifo.pop_front());
         if (pF) mFifo.push_back(inData);
      end
      #1;
   endtask

   task automatic idleInputs();
      addrIn = '0; addrIn_valid = 1'b0; addrOut_ready = 1'b1;
      dataFromMem = '0; dataFromMem_valid = 1'b0; dataOut_ready = 1'b0;
   endtask

   task automatic doReset();
      idleInputs();
      rst = 1'b1;
      modelClear();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      autoMem = 1'b0;
      mIssued = 0;
      dutDelivered = 0;
      tbl[0] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1};
      tbl[1] = '{1'b1, 32'hA5, 1'b0, 1'b1, 1'b0};
      tbl[2] = '{1'b1, 32'h20, 1'b1, 1'b1, 1'b1};
      tbl[3] = '{1'b1, 32'h21, 1'b1, 1'b1, 1'b1};
      tbl[4] = '{1'b0, 32'h5A, 1'b1, 1'b0, 1'b1};
      tbl[5] = '{1'b1, 32'h22, 1'b1, 1'b1, 1'b1};
      tbl[6] = '{1'b1, 32'h23, 1'b1, 1'b1, 1'b1};
      tbl[7] = '{1'b1, 32'h24, 1'b1, 1'b0, 1'b0};
      tbl[8] = '{1'b1, 32'h25, 1'b0, 1'b0, 1'b0};

      idleInputs();
      rst = 1'b1;
      modelClear();
      #2;
      chk("rst_dataOut_valid", dataOut_valid, 1'b0);
      chk("rst_dataFromMem_ready", dataFromMem_ready, 1'b1);
      chk("rst_addrIn_ready", addrIn_ready, 1'b1);
      addrIn_valid = 1'b1;
      #1;
      chk("rst_addrOut_valid_follows", addrOut_valid, 1'b1);
      doReset();

      // Address path and credit stall from the table.
      for (int i = 0; i < 9; i++) begin
         addrIn_valid = tbl[i].aiv; addrIn = tbl[i].addr; addrOut_ready = tbl[i].aor;
         #1;
         chk($sformatf("tbl%0d_addrOut_valid", i), addrOut_valid, tbl[i].eAov);
         chk($sformatf("tbl%0d_addrIn_ready", i), addrIn_ready, tbl[i].eAir);
         chk($sformatf("tbl%0d_addrOut", i), addrOut, tbl[i].addr);
         cyc();
      end

      // Fill the FIFO while the consumer stalls, then drain in order.
      addrIn_valid = 1'b0; addrOut_ready = 1'b1; dataOut_ready = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         dataFromMem_valid = 1'b1; dataFromMem = DW'(k);
         cyc();
      end
      dataFromMem_valid = 1'b0;
      #1;
      chk("full_dataFromMem_ready", dataFromMem_ready, 1'b0);
      chk("full_dataOut_valid", dataOut_valid, 1'b1);
      addrIn_valid = 1'b1; addrIn = 32'h40; dataOut_ready = 1'b1;
      #1;
      chk("retire_no_free", addrIn_ready, 1'b0);
      chk("drain1", dataOut, 32'h1);
      cyc();
      addrIn_valid = 1'b0;
      #1;
      chk("slot_freed", addrIn_ready, 1'b1);
      chk("drain2", dataOut, 32'h2);
      cyc();
      chk("drain3", dataOut, 32'h3);
      cyc();
      chk("drain4", dataOut, 32'h4);
      cyc();
      chk("drained_valid", dataOut_valid, 1'b0);

      // Issue and retire in the same cycle; push and pop together.
      dataOut_ready = 1'b0; addrIn_valid = 1'b1;
      addrIn = 32'h30; cyc();
      addrIn = 32'h31; cyc();
      addrIn_valid = 1'b0; dataFromMem_valid = 1'b1; dataFromMem = 32'hA1; cyc();
      addrIn_valid = 1'b1; addrIn = 32'h32; dataFromMem = 32'hA2; dataOut_ready = 1'b1;
      #1;
      chk("simul_dataOut", dataOut, 32'hA1);
      cyc();
      addrIn_valid = 1'b0; dataFromMem_valid = 1'b0; dataOut_ready = 1'b0;
      #1;
      chk("simul_occupancy_valid", dataOut_valid, 1'b1);
      chk("simul_head", dataOut, 32'hA2);
      addrIn_valid = 1'b1; addrIn = 32'h33; cyc();
      addrIn = 32'h34; cyc();
      chk("simul_counter_full", addrIn_ready, 1'b0);
      cyc();
      addrIn_valid = 1'b0;

      // Asynchronous reset with three words buffered.
      dataFromMem_valid = 1'b1; dataFromMem = 32'hB1; cyc();
      dataFromMem = 32'hB2; cyc();
      dataFromMem_valid = 1'b0;
      chk("pre_rst_valid", dataOut_valid, 1'b1);
      rst = 1'b1;
      #2;
      chk("async_dataOut_valid", dataOut_valid, 1'b0);
      chk("async_dataFromMem_ready", dataFromMem_ready, 1'b1);
      addrOut_ready = 1'b0;
      #1;
      chk("async_addrIn_ready_lo", addrIn_ready, 1'b0);
      addrOut_ready = 1'b1;
      #1;
      chk("async_addrIn_ready_hi", addrIn_ready, 1'b1);
      modelClear();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_addrIn_ready", addrIn_ready, 1'b1);
      chk("post_rst_dataOut_valid", dataOut_valid, 1'b0);

      // Single load latency.
      addrIn_valid = 1'b1; addrIn = 32'h10; cyc();
      addrIn_valid = 1'b0; cyc();
      dataFromMem_valid = 1'b1; dataFromMem = 32'hAB; dataOut_ready = 1'b1;
      #1;
      chk("lat_return_cycle", dataOut_valid, BYP);
      cyc();
      dataFromMem_valid = 1'b0;
      #1;
      chk("lat_next_cycle", dataOut_valid, !BYP);
      cyc();
      cyc();
      chk("single_done_ready", addrIn_ready, 1'b1);

      // Random traffic with an in-order memory model.
      doReset();
      autoMem = 1'b1;
      mIssued = 0;
      dutDelivered = 0;
      for (int i = 0; i < 3000; i++) begin
         addrIn_valid = 1'($urandom_range(0, 1));
         addrIn = $urandom;
         addrOut_ready = ($urandom_range(0, 3) != 0);
         dataFromMem_valid = (memQ.size() > 0) && ($urandom_range(0, 2) != 0);
         dataFromMem = (memQ.size() > 0) ? memQ[0] : DW'($urandom);
         dataOut_ready = ($urandom_range(0, 3) != 0);
         cyc();
      end
      addrIn_valid = 1'b0;
      dataOut_ready = 1'b1;
      for (int i = 0; i < 200 && (memQ.size() > 0 || mFifo.size() > 0); i++) begin
         dataFromMem_valid = (memQ.size() > 0);
         dataFromMem = (memQ.size() > 0) ? memQ[0] : '0;
         cyc();
      end
      dataFromMem_valid = 1'b0;
      #1;
      chk("drain_complete", dataOut_valid, 1'b0);
      chk("no_lost_or_dup", 64'(dutDelivered), 64'(mIssued));
      chk("final_addrIn_ready", addrIn_ready, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

endmodule

// File: doc/lsq_load_port.md
LSQ_LOAD_PORT -- requirements
Module: lsq_load_port

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, load data width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, load address width in bits.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 4, maximum number of issued loads whose data has not yet been delivered to the circuit; legal range 1..16.
REQ-004 SHALL use one clock and an asynchronous, active-high reset; the ports SHALL be declared in the following order, clock and reset first.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 addrIn  input  ADDR_WIDTH  load address from the circuit.
REQ-008 addrIn_valid  input  1  / addrIn_ready  output  1  handshake for addrIn.
REQ-009 addrOut  output  ADDR_WIDTH  load address to the memory interface.
REQ-010 addrOut_valid  output  1  / addrOut_ready  input  1  handshake for addrOut.
REQ-011 dataFromMem  input  DATA_WIDTH  load data returned by the memory interface, in request order.
REQ-012 dataFromMem_valid  input  1  / dataFromMem_ready  output  1  handshake for dataFromMem.
REQ-013 dataOut  output  DATA_WIDTH  load data to the circuit.
REQ-014 dataOut_valid  output  1  / dataOut_ready  input  1  handshake for dataOut.

Function
REQ-015 A channel SHALL transfer in a cycle only when its valid and ready are both high ("fire").
REQ-016 The block SHALL keep an outstanding counter, range 0..MAX_OUTSTANDING, with width ceil(log2(MAX_OUTSTANDING+1)).
REQ-017 The address path SHALL be combinational: addrOut = addrIn.
REQ-018 The address path SHALL drive addrOut_valid = addrIn_valid AND (outstanding < MAX_OUTSTANDING).
REQ-019 The address path SHALL drive addrIn_ready = addrOut_ready AND (outstanding < MAX_OUTSTANDING).
REQ-020 The counter SHALL increment on an addrOut fire, decrement on a dataOut fire, and stay unchanged when both fire in the same cycle.
REQ-021 Because of that same-cycle rule, a retire SHALL NOT free a slot combinationally in the same cycle; at outstanding == MAX_OUTSTANDING, addrIn_ready SHALL stay low even while dataOut fires.
REQ-022 Return data SHALL be held in a FIFO of depth MAX_OUTSTANDING, with read/write pointers wrapping modulo the depth and an occupancy count.
REQ-023 The FIFO SHALL drive dataFromMem_ready = (occupancy < MAX_OUTSTANDING).
REQ-024 A dataFromMem fire SHALL write the FIFO.
REQ-025 dataOut SHALL present the FIFO head, and dataOut_valid SHALL equal (occupancy > 0).
REQ-026 A dataOut fire SHALL pop the FIFO.
REQ-027 A simultaneous push and pop SHALL leave occupancy unchanged; at full, the push is refused (ready low) even if a pop occurs that cycle.
REQ-028 Data SHALL leave in arrival order; there is no reordering.
REQ-029 Default latency dataFromMem fire -> dataOut_valid SHALL be 1 cycle.
REQ-030 dataFromMem_valid arriving with outstanding == 0 is a protocol violation; behaviour is undefined apart from no FIFO overflow.

Reset
REQ-031 While rst is high, the outstanding counter, FIFO pointers and FIFO occupancy SHALL be 0 immediately, independent of clk.
REQ-032 During reset, dataOut_valid = 0, dataFromMem_ready = 1 and addrIn_ready = addrOut_ready.
REQ-033 During reset, addrOut_valid SHALL follow addrIn_valid; the circuit is required to hold valid low in reset.
REQ-034 Reset mid-operation SHALL discard all buffered data and outstanding credits.
REQ-035 FIFO storage contents need not be reset; dataOut is don't-care while dataOut_valid is low.

Configuration
REQ-036 Macro LSQ_LOAD_BYPASS_EN, when defined, SHALL enable a FIFO bypass.
REQ-037 With the bypass, when occupancy == 0 and dataFromMem_valid is high: dataOut = dataFromMem, dataOut_valid = 1.
REQ-038 With the bypass, if dataOut_ready is also high, the word SHALL transfer in the same cycle (0-cycle latency) without being written.
REQ-039 With the bypass, if dataOut_ready is low, the word SHALL be written to the FIFO as normal.
REQ-040 Without LSQ_LOAD_BYPASS_EN, dataOut SHALL always come from the FIFO, with a minimum 1-cycle latency.

Verification
REQ-041 Single load: MAX_OUTSTANDING=4, issue addr 0x10, return 0xAB two cycles later, dataOut_ready=1 -> addrOut=0x10 fires, dataOut=0xAB valid exactly 1 cycle after return (0 with bypass), outstanding back to 0.
REQ-042 Credit stall: issue 4 addresses with no returns -> 5th address sees addrIn_ready=0 and addrOut_valid=0; after one dataOut fire, addrIn_ready=1 on the next cycle.
REQ-043 Ordering/backpressure: return 0x1,0x2,0x3,0x4 with dataOut_ready=0 -> FIFO full and dataFromMem_ready=0; releasing ready delivers 0x1..0x4 in order on consecutive cycles.
REQ-044 Simultaneous events: with outstanding=2, addrOut and dataOut fire in the same cycle -> outstanding stays 2; push and pop together keep occupancy constant.
REQ-045 Async reset: assert rst mid-cycle with 3 words buffered -> dataOut_valid drops without a clock edge; after release, outstanding=0 and addrIn_ready follows addrOut_ready.
REQ-046 Wrap-around: 10 back-to-back loads with random dataOut_ready -> pointers wrap at 4 with no lost or duplicated data.
